// File: rtl/fmap_bram_reader.sv
// fmap_bram_reader: streams a packed feature map out of a 32-bit BRAM, one element per valid/ready beat
module fmap_bram_reader #(
    parameter int DATA_NUM  = 400,
    parameter int I_F_BW    = 8,
    localparam int B_COL_NUM = 32 / I_F_BW,
    localparam int B_DATA_D  = (DATA_NUM + B_COL_NUM - 1) / B_COL_NUM,
    localparam int B_ADDR_W  = B_DATA_D > 1 ? $clog2(B_DATA_D) : 1
) (
    input  logic                clk,
    input  logic                areset_n,
    input  logic                i_run,
    output logic                o_idle,
    output logic                o_run,
    output logic                o_en_err,
    output logic                o_done,
    output logic [B_ADDR_W-1:0] b_o_fmap_addr,
    output logic                b_o_fmap_ce,
    input  logic [31:0]         b_i_fmap_q,
    output logic                o_ot_valid,
    input  logic                i_ot_ready,
    output logic [I_F_BW-1:0]   o_ot_data,
    output logic                o_ot_last
);
    localparam int LW = B_COL_NUM > 1 ? $clog2(B_COL_NUM) : 1;
    localparam int CW = $clog2(DATA_NUM + 1);
    localparam int IW = $clog2(B_DATA_D + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              r_state;
    logic                r_idle;
    logic                r_done;
    logic                r_err;
    logic [B_ADDR_W-1:0] r_addr;
    logic [IW-1:0]       r_issued;
    logic                r_inflight;
    logic [31:0]         r_fifo [3];
    logic [1:0]          r_wp;
    logic [1:0]          r_rp;
    logic [1:0]          r_occ;
    logic                r_valid;
    logic [I_F_BW-1:0]   r_data;
    logic                r_last;
    logic [CW-1:0]       r_cnt;
    logic [LW-1:0]       r_lane;

    state_t              w_next;
    logic                w_start;
    logic                w_issue;
    logic                w_fifo_empty;
    logic                w_src_vld;
    logic [31:0]         w_src;
    logic [I_F_BW-1:0]   w_lane;
    logic                w_load;
    logic                w_is_last;
    logic                w_pop;
    logic                w_pop_fifo;
    logic                w_push;

    assign w_start      = (r_state == S_IDLE) && i_run;
    assign w_issue      = (r_state == S_RUN) && (r_issued < IW'(B_DATA_D))
                          && (({1'b0, r_occ} + 3'(r_inflight)) < 3'd3);
    assign w_fifo_empty = (r_occ == 2'd0);
    assign w_src_vld    = !w_fifo_empty || r_inflight;
    // An empty FIFO lets the word arriving from the BRAM be unpacked directly.
    assign w_src        = w_fifo_empty ? b_i_fmap_q : r_fifo[r_rp];
    assign w_load       = (r_state == S_RUN) && w_src_vld && (!r_valid || i_ot_ready)
                          && (r_cnt < CW'(DATA_NUM));
    assign w_is_last    = (r_cnt == CW'(DATA_NUM - 1));
    assign w_pop        = w_load && ((r_lane == LW'(B_COL_NUM - 1)) || w_is_last);
    assign w_pop_fifo   = w_pop && !w_fifo_empty;
    assign w_push       = r_inflight && !(w_fifo_empty && w_pop);
    assign w_next       = w_start ? S_RUN :
                          (r_state == S_RUN && r_valid && i_ot_ready && r_last) ? S_DONE :
                          (r_state == S_DONE) ? S_IDLE : r_state;

    assign o_idle        = r_idle;
    assign o_run         = !r_idle;
    assign o_en_err      = r_err;
    assign o_done        = r_done;
    assign b_o_fmap_addr = r_addr;
    assign b_o_fmap_ce   = w_issue;
    assign o_ot_valid    = r_valid;
    assign o_ot_data     = r_data;
    assign o_ot_last     = r_last;

    // Select the current lane of the source word.
    always_comb begin
        w_lane = '0;
        for (int j = 0; j < B_COL_NUM; j++)
            if (r_lane == LW'(j)) w_lane = w_src[j*I_F_BW +: I_F_BW];
    end

    // Run-control FSM with registered status flags; busy i_run latches the error.
    always_ff @(posedge clk) begin
        if (!areset_n) begin
            r_state <= S_IDLE;
            r_idle  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idle  <= (w_next == S_IDLE);
            r_done  <= (w_next == S_DONE);
            if (i_run && r_state != S_IDLE) r_err <= 1'b1;
        end
    end

    // Read issue: address walks 0..B_DATA_D-1 and holds at the final word.
    always_ff @(posedge clk) begin
        if (!areset_n) begin
            r_addr     <= '0;
            r_issued   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_start) begin
                r_addr   <= '0;
                r_issued <= '0;
            end else if (w_issue) begin
                r_issued <= r_issued + 1'b1;
                if (r_issued != IW'(B_DATA_D - 1)) r_addr <= r_addr + 1'b1;
            end
        end
    end

    // Three-entry word FIFO; read credits keep it from overflowing.
    always_ff @(posedge clk) begin
        if (!areset_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_occ <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wp] <= b_i_fmap_q;
                r_wp         <= (r_wp == 2'd2) ? 2'd0 : r_wp + 2'd1;
            end
            if (w_pop_fifo) r_rp <= (r_rp == 2'd2) ? 2'd0 : r_rp + 2'd1;
            r_occ <= r_occ + 2'(w_push) - 2'(w_pop_fifo);
        end
    end

    // Output register: holds data while stalled, reloads on every accepted beat.
    always_ff @(posedge clk) begin
        if (!areset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
            r_lane  <= '0;
        end else if (w_start) begin
            r_cnt  <= '0;
            r_lane <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= w_lane;
            r_last  <= w_is_last;
            r_cnt   <= r_cnt + 1'b1;
            r_lane  <= w_pop ? '0 : r_lane + 1'b1;
        end else if (r_valid && i_ot_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fmap_bram_reader.sv
// tb_fmap_bram_reader: randomized stream checks of fmap_bram_reader against an element-level model
module tb_fmap_bram_reader;
    logic        clk = 1'b0;
    logic        areset_n = 1'b0;
    logic        ready = 1'b0;
    logic [2:0]  run_v = '0;
    logic [2:0]  idle_v, orun_v, err_v, done_v, ce_v, valid_v, last_v;
    logic [6:0]  addr0;
    logic [1:0]  addr1;
    logic [3:0]  addr2;
    logic [7:0]  data0, data1;
    logic [31:0] data2;
    logic [31:0] q0, q1, q2;
    logic [1:0]  sel = '0;
    logic [31:0] s_addr, s_data;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    fmap_bram_reader #(.DATA_NUM(400), .I_F_BW(8)) u_d0 (
        .clk(clk), .areset_n(areset_n), .i_run(run_v[0]), .o_idle(idle_v[0]), .o_run(orun_v[0]),
        .o_en_err(err_v[0]), .o_done(done_v[0]), .b_o_fmap_addr(addr0), .b_o_fmap_ce(ce_v[0]),
        .b_i_fmap_q(q0), .o_ot_valid(valid_v[0]), .i_ot_ready(ready), .o_ot_data(data0), .o_ot_last(last_v[0]));
    fmap_bram_reader #(.DATA_NUM(10), .I_F_BW(8)) u_d1 (
        .clk(clk), .areset_n(areset_n), .i_run(run_v[1]), .o_idle(idle_v[1]), .o_run(orun_v[1]),
        .o_en_err(err_v[1]), .o_done(done_v[1]), .b_o_fmap_addr(addr1), .b_o_fmap_ce(ce_v[1]),
        .b_i_fmap_q(q1), .o_ot_valid(valid_v[1]), .i_ot_ready(ready), .o_ot_data(data1), .o_ot_last(last_v[1]));
    fmap_bram_reader #(.DATA_NUM(16), .I_F_BW(32)) u_d2 (
        .clk(clk), .areset_n(areset_n), .i_run(run_v[2]), .o_idle(idle_v[2]), .o_run(orun_v[2]),
        .o_en_err(err_v[2]), .o_done(done_v[2]), .b_o_fmap_addr(addr2), .b_o_fmap_ce(ce_v[2]),
        .b_i_fmap_q(q2), .o_ot_valid(valid_v[2]), .i_ot_ready(ready), .o_ot_data(data2), .o_ot_last(last_v[2]));

    function automatic logic [31:0] bram_word(input int w);
        return {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
    endfunction

    // Expected element n: bytes are packed in ascending order, so an 8-bit stream is just n mod 256.
    function automatic logic [31:0] exp_elem(input int s, input int n);
        return (s == 2) ? bram_word(n) : 32'(n % 256);
    endfunction

    // BRAM models with one cycle read latency.
    always @(posedge clk) begin
        if (ce_v[0]) q0 <= bram_word(int'(addr0));
        if (ce_v[1]) q1 <= bram_word(int'(addr1));
        if (ce_v[2]) q2 <= bram_word(int'(addr2));
    end

    always_comb begin
        s_addr = (sel == 2'd0) ? 32'(addr0) : (sel == 2'd1) ? 32'(addr1) : 32'(addr2);
        s_data = (sel == 2'd0) ? 32'(data0) : (sel == 2'd1) ? 32'(data1) : data2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One run on DUT s: n elements, ready high with probability pct%, optional busy i_run at
    // beat err_at, optional reset at beat rst_at (checks post-reset state then returns).
    task automatic do_run(input int s, input int n, input int col, input int pct,
                          input int err_at, input int rst_at);
        int  t = 0, hs = 0, ce_n = 0, first_t = -1, done_t = -1, done_n = 0;
        int  d = (n + col - 1) / col;
        bit  rdy, pv_stall = 0, err_sent = 0;
        logic [31:0] pv_data = '0;
        logic pv_last = 1'b0;
        sel = 2'(s);
        @(negedge clk);
        run_v[s] = 1'b1;
        ready = ($urandom_range(99) < pct);
        for (t = 1; t < n * 20 + 50; t++) begin
            @(negedge clk);
            run_v[s] = 1'b0;
            chk("fifo_bound", 32'((ce_n - (hs + int'(valid_v[s])) / col) <= 3), 1);
            if (ce_v[s]) begin
                chk("addr", s_addr, ce_n);
                ce_n++;
            end
            if (pv_stall) begin
                chk("stall_valid", valid_v[s], 1);
                chk("stall_data", s_data, pv_data);
                chk("stall_last", last_v[s], pv_last);
            end
            if (valid_v[s] && first_t < 0) first_t = t;
            rdy = ($urandom_range(99) < pct);
            ready = rdy;
            if (valid_v[s] && rdy) begin
                chk("data", s_data, exp_elem(s, hs));
                chk("last", last_v[s], 32'(hs == n - 1));
                hs++;
            end
            pv_stall = valid_v[s] && !rdy;
            pv_data = s_data;
            pv_last = last_v[s];
            if (done_v[s]) begin
                done_n++;
                done_t = t;
            end
            if (done_n > 0 && t == done_t + 1) chk("idle_after_done", idle_v[s], 1);
            if (err_at >= 0 && hs == err_at && !err_sent) begin
                run_v[s] = 1'b1;
                err_sent = 1;
            end
            if (rst_at >= 0 && hs == rst_at) begin
                areset_n = 1'b0;
                @(negedge clk);
                chk("rst_idle", idle_v[s], 1);
                chk("rst_valid", valid_v[s], 0);
                chk("rst_err", err_v[s], 0);
                chk("rst_addr", s_addr, 0);
                areset_n = 1'b1;
                ready = 1'b0;
                return;
            end
            if (done_n > 0 && t == done_t + 3) break;
        end
        ready = 1'b0;
        chk("beats", hs, n);
        chk("done_count", done_n, 1);
        chk("ce_count", ce_n, d);
        chk("first_valid", first_t, 3);
        chk("err_flag", err_v[s], 32'(err_at >= 0));
        if (pct == 100) chk("done_cycle", done_t, n + 3);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            chk("reset_idle", idle_v[s], 1);
            chk("reset_run", orun_v[s], 0);
            chk("reset_out", {err_v[s], done_v[s], ce_v[s], valid_v[s], last_v[s]}, 0);
            chk("reset_addr", s_addr, 0);
        end
        areset_n = 1'b1;
        do_run(0, 400, 4, 100, -1, -1);
        do_run(0, 400, 4, 30, -1, -1);
        do_run(0, 400, 4, 100, 50, -1);
        do_run(0, 400, 4, 100, -1, 150);
        do_run(0, 400, 4, 100, -1, -1);
        do_run(1, 10, 4, 100, -1, -1);
        do_run(1, 10, 4, 50, -1, -1);
        do_run(2, 16, 1, 100, -1, -1);
        do_run(2, 16, 1, 40, -1, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
